// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a 2-entry elastic buffer.
// Each entry carries {immediate, format, illegal, tag} to the consumer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [31:0]      instruction_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [XLEN-1:0]  immediate_out,
  output logic [2:0]       imm_fmt_out,
  output logic             illegal_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_V    = 3'd7;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_OPV    = 5'b10101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [31:0]     w_inst;
  logic [4:0]      w_op;
  logic            w_sgn;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_z;
  logic [XLEN-1:0] w_imm_v;
  logic [XLEN-1:0] w_shamt;
  logic            w_shift;
  logic            w_sh_bad;

  assign w_inst  = instruction_in;
  assign w_op    = w_inst[6:2];
  assign w_sgn   = w_inst[31];
  assign w_imm_i = {{(XLEN-12){w_sgn}}, w_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){w_sgn}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){w_sgn}}, w_inst[31], w_inst[7],
                    w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){w_sgn}}, w_inst[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){w_sgn}}, w_inst[31], w_inst[19:12],
                    w_inst[20], w_inst[30:21], 1'b0};
  assign w_imm_z = {{(XLEN-5){1'b0}}, w_inst[19:15]};
  assign w_imm_v = {{(XLEN-5){w_inst[19]}}, w_inst[19:15]};

  // funct3 001 (sll) and 101 (srl/sra) carry a shamt, not an immediate
  assign w_shift  = (w_inst[13:12] == 2'b01);
  assign w_shamt  = (XLEN == 32) ? {{(XLEN-5){1'b0}}, w_inst[24:20]}
                                 : {{(XLEN-6){1'b0}}, w_inst[25:20]};
  assign w_sh_bad = (XLEN == 32) && w_inst[25];

  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_ill;

  always_comb begin
    w_imm = '0;
    w_fmt = FMT_NONE;
    w_ill = 1'b0;
    if (w_inst[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      unique case (w_op)
        OP_LOAD, OP_MISC, OP_JALR: begin
          w_imm = w_imm_i;
          w_fmt = FMT_I;
        end
        OP_OPIMM: begin
          w_fmt = FMT_I;
          if (w_shift) begin
            w_imm = w_shamt;
            w_ill = w_sh_bad;
          end else begin
            w_imm = w_imm_i;
          end
        end
        OP_STORE: begin
          w_imm = w_imm_s;
          w_fmt = FMT_S;
        end
        OP_BRANCH: begin
          w_imm = w_imm_b;
          w_fmt = FMT_B;
        end
        OP_LUI, OP_AUIPC: begin
          w_imm = w_imm_u;
          w_fmt = FMT_U;
        end
        OP_JAL: begin
          w_imm = w_imm_j;
          w_fmt = FMT_J;
        end
        OP_SYSTEM: begin
          w_imm = w_imm_z;
          w_fmt = FMT_Z;
        end
        OP_OPV: begin
          w_imm = w_imm_v;
          w_fmt = FMT_V;
        end
        OP_OP: begin
          w_fmt = FMT_NONE;
        end
        default: begin
          w_ill = 1'b1;
        end
      endcase
    end
  end

  logic [XLEN-1:0]  r_imm [2];
  logic [2:0]       r_fmt [2];
  logic             r_ill [2];
  logic [TAG_W-1:0] r_tag [2];
  logic [1:0]       r_count;
  logic             r_head;
  logic             r_tail;

  logic w_push;
  logic w_pop;

  assign ready_in  = (r_count != 2'd2);
  assign valid_out = (r_count != 2'd0);
  assign w_push    = valid_in & ready_in & ~flush_in;
  assign w_pop     = valid_out & ready_out & ~flush_in;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_imm[i] <= '0;
        r_fmt[i] <= '0;
        r_ill[i] <= 1'b0;
        r_tag[i] <= '0;
      end
    end else if (flush_in) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_push) begin
        r_imm[r_tail] <= w_imm;
        r_fmt[r_tail] <= w_fmt;
        r_ill[r_tail] <= w_ill;
        r_tag[r_tail] <= tag_in;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Outputs read as zero whenever nothing is presented
  assign immediate_out = valid_out ? r_imm[r_head] : '0;
  assign imm_fmt_out   = valid_out ? r_fmt[r_head] : '0;
  assign illegal_out   = valid_out ? r_ill[r_head] : 1'b0;
  assign tag_out       = valid_out ? r_tag[r_head] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table, XLEN=64 decode,
// backpressure ordering, flush and asynchronous reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        vin;
  logic        rdy_in;
  logic [31:0] inst;
  logic [31:0] tag;
  logic        vout;
  logic        rdy_out;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        ill;
  logic [31:0] tag_o;

  logic        flush64;
  logic        vin64;
  logic        rdy_in64;
  logic [31:0] inst64;
  logic [31:0] tag64;
  logic        vout64;
  logic        rdy_out64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        ill64;
  logic [31:0] tag64_o;

  int pass_cnt = 0;
  int total    = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clock_in       (clk),
    .reset_in       (rst),
    .flush_in       (flush),
    .valid_in       (vin),
    .ready_in       (rdy_in),
    .instruction_in (inst),
    .tag_in         (tag),
    .valid_out      (vout),
    .ready_out      (rdy_out),
    .immediate_out  (imm),
    .imm_fmt_out    (fmt),
    .illegal_out    (ill),
    .tag_out        (tag_o)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clock_in       (clk),
    .reset_in       (rst),
    .flush_in       (flush64),
    .valid_in       (vin64),
    .ready_in       (rdy_in64),
    .instruction_in (inst64),
    .tag_in         (tag64),
    .valid_out      (vout64),
    .ready_out      (rdy_out64),
    .immediate_out  (imm64),
    .imm_fmt_out    (fmt64),
    .illegal_out    (ill64),
    .tag_out        (tag64_o)
  );

  localparam int ND = 14;
  logic [31:0] d_inst [ND] = '{
    32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h001000EF,
    32'h123452B7, 32'h4030D093, 32'h000F8073, 32'h00080057,
    32'h00000033, 32'h0000007F, 32'h02009093, 32'h00000010,
    32'h80000067, 32'h7FF02003
  };
  logic [31:0] d_imm [ND] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
    32'h12345000, 32'h00000003, 32'h0000001F, 32'hFFFFFFF0,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'hFFFFF800, 32'h000007FF
  };
  logic [2:0] d_fmt [ND] = '{
    3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd1, 3'd6, 3'd7,
    3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1
  };
  logic d_ill [ND] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0
  };

  task automatic test_reset;
    total++;
    if (vout !== 1'b0 || rdy_in !== 1'b1 || imm !== 32'h0 ||
        fmt !== 3'd0 || ill !== 1'b0 || tag_o !== 32'h0) begin
      $display("FAIL reset_state vout=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%h exp 0/1/0/0/0/0",
               vout, rdy_in, imm, fmt, ill, tag_o);
    end else pass_cnt++;
    total++;
    if (vout64 !== 1'b0 || rdy_in64 !== 1'b1 || imm64 !== 64'h0) begin
      $display("FAIL reset_state64 vout=%b rdy=%b imm=%h exp 0/1/0",
               vout64, rdy_in64, imm64);
    end else pass_cnt++;
  endtask

  task automatic test_decode;
    rdy_out = 1'b1;
    for (int i = 0; i < ND; i++) begin
      inst = d_inst[i];
      tag  = 32'h1000 + 32'(i);
      vin  = 1'b1;
      @(posedge clk); #1;
      vin = 1'b0;
      total++;
      if (vout !== 1'b1 || imm !== d_imm[i] || fmt !== d_fmt[i] ||
          ill !== d_ill[i] || tag_o !== 32'h1000 + 32'(i)) begin
        $display("FAIL decode[%0d] inst=%h got v=%b imm=%h fmt=%0d ill=%b tag=%h exp imm=%h fmt=%0d ill=%b",
                 i, d_inst[i], vout, imm, fmt, ill, tag_o,
                 d_imm[i], d_fmt[i], d_ill[i]);
      end else pass_cnt++;
      @(posedge clk); #1;
      total++;
      if (vout !== 1'b0 || imm !== 32'h0) begin
        $display("FAIL drain[%0d] vout=%b imm=%h exp 0/0", i, vout, imm);
      end else pass_cnt++;
    end
  endtask

  task automatic test_xlen64;
    logic [31:0] xi [3];
    logic [63:0] xe [3];
    logic [2:0]  xf [3];
    xi = '{32'h800002B7, 32'h02809093, 32'hFFF00093};
    xe = '{64'hFFFFFFFF80000000, 64'h28, 64'hFFFFFFFFFFFFFFFF};
    xf = '{3'd4, 3'd1, 3'd1};
    for (int i = 0; i < 3; i++) begin
      inst64 = xi[i];
      tag64  = 32'hA0 + 32'(i);
      vin64  = 1'b1;
      @(posedge clk); #1;
      vin64 = 1'b0;
      total++;
      if (vout64 !== 1'b1 || imm64 !== xe[i] || fmt64 !== xf[i] ||
          ill64 !== 1'b0 || tag64_o !== 32'hA0 + 32'(i)) begin
        $display("FAIL x64[%0d] got v=%b imm=%h fmt=%0d ill=%b exp imm=%h fmt=%0d ill=0",
                 i, vout64, imm64, fmt64, ill64, xe[i], xf[i]);
      end else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    rdy_out = 1'b0;
    inst = 32'h00100093; tag = 32'h100; vin = 1'b1;
    @(posedge clk); #1;
    total++;
    if (vout !== 1'b1 || rdy_in !== 1'b1 || imm !== 32'd1) begin
      $display("FAIL bp_A v=%b rdy=%b imm=%h exp 1/1/1", vout, rdy_in, imm);
    end else pass_cnt++;
    inst = 32'h00200093; tag = 32'h104;
    @(posedge clk); #1;
    total++;
    if (rdy_in !== 1'b0 || imm !== 32'd1 || tag_o !== 32'h100) begin
      $display("FAIL bp_full rdy=%b imm=%h tag=%h exp 0/1/100", rdy_in, imm, tag_o);
    end else pass_cnt++;
    inst = 32'h00300093; tag = 32'h108;
    @(posedge clk); #1;
    total++;
    if (rdy_in !== 1'b0 || vout !== 1'b1 || imm !== 32'd1 || tag_o !== 32'h100) begin
      $display("FAIL bp_hold rdy=%b v=%b imm=%h tag=%h exp 0/1/1/100",
               rdy_in, vout, imm, tag_o);
    end else pass_cnt++;
    rdy_out = 1'b1;
    @(posedge clk); #1;
    total++;
    if (vout !== 1'b1 || imm !== 32'd2 || tag_o !== 32'h104 || rdy_in !== 1'b1) begin
      $display("FAIL bp_B v=%b imm=%h tag=%h rdy=%b exp 1/2/104/1",
               vout, imm, tag_o, rdy_in);
    end else pass_cnt++;
    @(posedge clk); #1;
    vin = 1'b0;
    total++;
    if (vout !== 1'b1 || imm !== 32'd3 || tag_o !== 32'h108) begin
      $display("FAIL bp_C v=%b imm=%h tag=%h exp 1/3/108", vout, imm, tag_o);
    end else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (vout !== 1'b0) begin
      $display("FAIL bp_empty v=%b exp 0", vout);
    end else pass_cnt++;
  endtask

  task automatic test_flush;
    rdy_out = 1'b0;
    inst = 32'h00500093; tag = 32'h200; vin = 1'b1;
    @(posedge clk); #1;
    inst = 32'h00600093; tag = 32'h204;
    @(posedge clk); #1;
    total++;
    if (vout !== 1'b1 || rdy_in !== 1'b0) begin
      $display("FAIL flush_pre v=%b rdy=%b exp 1/0", vout, rdy_in);
    end else pass_cnt++;
    flush = 1'b1;
    inst = 32'h00700093; tag = 32'h208;
    @(posedge clk); #1;
    flush = 1'b0; vin = 1'b0;
    total++;
    if (vout !== 1'b0 || rdy_in !== 1'b1 || imm !== 32'h0 || tag_o !== 32'h0) begin
      $display("FAIL flush_full v=%b rdy=%b imm=%h tag=%h exp 0/1/0/0",
               vout, rdy_in, imm, tag_o);
    end else pass_cnt++;
    inst = 32'h00800093; tag = 32'h20C; vin = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    inst = 32'h00900093; tag = 32'h210;
    @(posedge clk); #1;
    flush = 1'b0; vin = 1'b0;
    total++;
    if (vout !== 1'b0 || rdy_in !== 1'b1) begin
      $display("FAIL flush_one v=%b rdy=%b exp 0/1", vout, rdy_in);
    end else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (vout !== 1'b0) begin
      $display("FAIL flush_nopush v=%b imm=%h exp 0", vout, imm);
    end else pass_cnt++;
  endtask

  task automatic test_async_reset;
    rdy_out = 1'b0;
    inst = 32'h00A00093; tag = 32'h300; vin = 1'b1;
    @(posedge clk); #1;
    inst = 32'h00B00093; tag = 32'h304;
    @(posedge clk); #1;
    vin = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (vout !== 1'b0 || rdy_in !== 1'b1 || imm !== 32'h0 ||
        fmt !== 3'd0 || tag_o !== 32'h0) begin
      $display("FAIL async_rst v=%b rdy=%b imm=%h fmt=%0d tag=%h exp 0/1/0/0/0",
               vout, rdy_in, imm, fmt, tag_o);
    end else pass_cnt++;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    total++;
    if (vout !== 1'b0 || imm !== 32'h0) begin
      $display("FAIL rst_release v=%b imm=%h exp 0/0", vout, imm);
    end else pass_cnt++;
    @(posedge clk); #1;
    inst = 32'h00C00093; tag = 32'h308; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    total++;
    if (vout !== 1'b1 || imm !== 32'd12 || tag_o !== 32'h308) begin
      $display("FAIL rst_first v=%b imm=%h tag=%h exp 1/c/308", vout, imm, tag_o);
    end else pass_cnt++;
    rdy_out = 1'b1;
    @(posedge clk); #1;
    total++;
    if (vout !== 1'b0) begin
      $display("FAIL rst_drain v=%b exp 0", vout);
    end else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; vin = 1'b0; inst = '0; tag = '0; rdy_out = 1'b1;
    flush64 = 1'b0; vin64 = 1'b0; inst64 = '0; tag64 = '0; rdy_out64 = 1'b1;
    #2;
    test_reset;
    #10 rst = 1'b0;
    @(posedge clk); #1;
    test_decode;
    test_xlen64;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, buffered immediate generator for the DEC stage. It accepts full 32-bit RISC-V instructions over a valid/ready handshake and decodes every base immediate format plus CSR-zimm and vector simm5. Results pass through a 2-entry elastic buffer, so IF/DEC backpressure never drops an instruction. An optional sideband tag, such as the PC, travels with each result.

## Interface
- XLEN, 32: output width; legal values are 32 and 64.
- TAG_W, 32: width of the pass-through tag.
- clock_in  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- flush_in  input  1  synchronous flush; empties the buffer.
- valid_in  input  1  instruction_in and tag_in are valid.
- ready_in  output  1  the block can accept this cycle.
- instruction_in  input  32  full instruction word.
- tag_in  input  TAG_W  sideband data, such as the PC.
- valid_out  output  1  the head entry is valid.
- ready_out  input  1  the consumer accepts the head entry.
- immediate_out  output  XLEN  decoded immediate.
- imm_fmt_out  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 V.
- illegal_out  output  1  the opcode or shamt is not supported.
- tag_out  output  TAG_W  tag of the head entry.

## Operation
- The decode is combinational on instruction_in. Select on opcode = inst[6:2]. The immediate is sign-extended from inst[31] to XLEN unless stated otherwise.
  - LOAD 00000, MISC-MEM 00011, JALR 11001: I format, {inst[31:20]}.
  - OPIMM 00100 with funct3 001 or 101: zero-extended shamt, format I.
    - The shamt is inst[24:20] when XLEN=32.
    - The shamt is inst[25:20] when XLEN=64.
    - XLEN=32 with inst[25]=1 sets illegal.
  - OPIMM 00100 with any other funct3: I format.
  - STORE 01000: S format, {inst[31:25], inst[11:7]}.
  - BRANCH 11000: B format, {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - LUI 01101, AUIPC 00101: U format, {inst[31:12], 12'b0}, sign-extended when XLEN=64.
  - JAL 11011: J format, {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - SYSTEM 11100: Z format, zero-extended inst[19:15].
  - OPV 10101: V format, sign-extended inst[19:15].
  - OP 01100: NONE, immediate 0, legal.
  - Any other opcode, or inst[1:0] != 2'b11: NONE, immediate 0, illegal = 1.
- The buffer is 2 entries, each holding {immediate, fmt, illegal, tag}. A 2-bit count and 1-bit head/tail pointers track occupancy.
- ready_in = (count != 2). It is a function of registered state only and has no combinational path from ready_out.
- push = valid_in & ready_in & ~flush_in. pop = valid_out & ready_out & ~flush_in.
- count evolves as count + push − pop. Pointers toggle on push or pop respectively, with wrap at 2.
- valid_out = (count != 0).
- When valid_out = 0, immediate_out, imm_fmt_out, illegal_out and tag_out are all driven to 0.
- flush_in has priority over push and pop. count → 0 and both pointers → 0. A same-cycle valid_in is discarded; it is not accepted.
- Reset (asynchronous, takes effect immediately):
  - count = 0, so valid_out = 0 and ready_in = 1.
  - All pointers and storage are cleared, so every data output reads 0.
- Reset mid-operation discards all buffered entries. No output glitches to a stale entry after release.

## Timing
- Latency is 1 cycle. An entry accepted at edge N is presented with valid_out = 1 after edge N, if the buffer was empty.
- Throughput is 1 per cycle while ready_out = 1. With count = 1, a push and a pop together keep count at 1.
- Full (count = 2): ready_in = 0 and the upstream holds. The first pop re-opens ready_in the next cycle.
- Empty: a pop is impossible because valid_out = 0. A push alone makes count 1.
- Head data is stable while valid_out = 1 and ready_out = 0. It is never overwritten by a push.
- Entries leave in FIFO order, including across pointer wrap.

## Test plan
- Format decode, XLEN=32, ready_out tied to 1. Each entry is instruction → immediate_out / imm_fmt_out:
  - 0xFFF00093 → 0xFFFFFFFF / I
  - 0xFE112E23 → 0xFFFFFFFC / S
  - 0xFE000CE3 → 0xFFFFFFF8 / B
  - 0x001000EF → 0x00000800 / J
  - 0x123452B7 → 0x12345000 / U
  - 0x4030D093 (srai 3) → 0x00000003 / I
  - All of the above with illegal_out = 0.
- Illegal cases:
  - 0x0000007F → immediate_out 0, NONE, illegal_out = 1.
  - XLEN=32 slli with inst[25]=1 → illegal_out = 1.
- XLEN=64:
  - 0x800002B7 → 0xFFFFFFFF80000000 / U.
  - slli with shamt 40 → 0x28, legal.
- Backpressure:
  - Hold ready_out = 0 and push A, B, C: ready_in drops to 0 after B, C is held upstream, and A stays on the outputs.
  - Release ready_out: A, B, C emerge in order with no gap after the first.
- Flush: with 2 entries buffered, assert flush_in together with valid_in → next cycle valid_out = 0, count = 0, ready_in = 1, and the new instruction is not output.
- Reset: assert reset_in asynchronously mid-stream with a full buffer → valid_out = 0 and all outputs 0 immediately. After release, the first new instruction appears 1 cycle after its accept.
